// File: rtl/apb_master_pkg.sv
// Shared definitions for the APB master bridge: FSM state encoding,
// slave index constants and the address-map base/mask constants.
package apb_master_pkg;

    // FSM state encoding
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_SETUP  = 2'd1;
    localparam state_t ST_ACCESS = 2'd2;
    localparam state_t ST_RESP   = 2'd3;

    // Slave indices into psel/pready/pslverr
    localparam int NUM_SLAVES = 2;
    localparam int SLV_UART   = 0;
    localparam int SLV_GPIO   = 1;

    // Address map: each slave owns one 4 KiB region
    localparam logic [63:0] REGION_MASK = 64'hFFFF_FFFF_FFFF_F000;
    localparam logic [63:0] UART_BASE   = 64'h0000_0000_0000_0000;
    localparam logic [63:0] GPIO_BASE   = 64'h0000_0000_0000_1000;

endpackage

// File: rtl/apb_addr_decode.sv
// Combinational address decoder: maps a byte address to a one-hot slave
// select, or flags a miss when no slave region matches.
module apb_addr_decode
    import apb_master_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic [ADDR_W-1:0]     addr,
    output logic [NUM_SLAVES-1:0] sel,
    output logic                  miss
);

    localparam logic [ADDR_W-1:0] MASK_W = REGION_MASK[ADDR_W-1:0];
    localparam logic [ADDR_W-1:0] UART_W = UART_BASE[ADDR_W-1:0];
    localparam logic [ADDR_W-1:0] GPIO_W = GPIO_BASE[ADDR_W-1:0];

    // Compare the masked address against each region base
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        sel           = '0;
        sel[SLV_UART] = ((addr & MASK_W) == UART_W);
        sel[SLV_GPIO] = ((addr & MASK_W) == GPIO_W);
        miss          = ~|sel;
    end

endmodule

// File: rtl/apb_master_bridge.sv
// Single-outstanding command to APB master bridge with two slaves
// (UART, GPIO). One command is accepted in IDLE, run through
// SETUP/ACCESS, and answered with a one-cycle rsp_valid pulse in RESP.
// Optional ACCESS-phase timeout: define APB_TIMEOUT_EN.
module apb_master_bridge
    import apb_master_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int ADDR_W         = 32
) (
    input  logic                  pclk,
    input  logic                  rst,
    // command side
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_W-1:0]     cmd_addr,
    input  logic [31:0]           cmd_wdata,
    input  logic [3:0]            cmd_strb,
    // response side
    output logic                  rsp_valid,
    output logic [31:0]           rsp_rdata,
    output logic                  rsp_err,
    output logic                  rsp_timeout,
    // APB side
    output logic [NUM_SLAVES-1:0] psel,
    output logic                  penable,
    output logic                  pwrite,
    output logic [ADDR_W-1:0]     paddr,
    output logic [31:0]           pwdata,
    output logic [3:0]            pstrb,
    input  logic [NUM_SLAVES-1:0] pready,
    input  logic [NUM_SLAVES-1:0] pslverr,
    input  logic [31:0]           prdata_uart,
    input  logic [31:0]           prdata_gpio
);

    state_t                state;
    logic [NUM_SLAVES-1:0] dec_sel;
    logic                  dec_miss;
    logic                  sel_ready;
    logic                  sel_err;
    logic [31:0]           sel_rdata;

`ifdef APB_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [CNT_W-1:0] wait_cnt;
`endif

    apb_addr_decode #(
        .ADDR_W (ADDR_W)
    ) u_decode (
        .addr (cmd_addr),
        .sel  (dec_sel),
        .miss (dec_miss)
    );

    // Pick ready/error/read data of the currently selected slave only
    always_comb begin
        sel_ready = |(psel & pready);
        sel_err   = |(psel & pslverr);
        sel_rdata = psel[SLV_GPIO] ? prdata_gpio : prdata_uart;
    end

    // Transfer FSM with fully registered APB and response outputs
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            cmd_ready <= 1'b0;
            psel      <= '0;
            penable   <= 1'b0;
            pwrite    <= 1'b0;
            paddr     <= '0;
            pwdata    <= '0;
            pstrb     <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
`ifdef APB_TIMEOUT_EN
            rsp_timeout <= 1'b0;
            wait_cnt    <= '0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every register updates from pre-edge values.
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
`ifdef APB_TIMEOUT_EN
            rsp_timeout <= 1'b0;
`endif
            case (state)
                ST_IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        cmd_ready <= 1'b0;
                        pwrite    <= cmd_write;
                        paddr     <= cmd_addr;
                        pwdata    <= cmd_write ? cmd_wdata : 32'd0;
                        pstrb     <= cmd_write ? cmd_strb  : 4'd0;
                        if (dec_miss) begin
                            // No APB cycle for unmapped addresses
                            state     <= ST_RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                        end else begin
                            psel  <= dec_sel;
                            state <= ST_SETUP;
                        end
                    end else begin
                        // Also raises ready on the first edge after reset
                        cmd_ready <= 1'b1;
                    end
                end
                ST_SETUP: begin
                    penable <= 1'b1;
                    state   <= ST_ACCESS;
`ifdef APB_TIMEOUT_EN
                    wait_cnt <= '0;
`endif
                end
                ST_ACCESS: begin
                    if (sel_ready) begin
                        psel      <= '0;
                        penable   <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_err   <= sel_err;
                        rsp_rdata <= pwrite ? 32'd0 : sel_rdata;
                        state     <= ST_RESP;
                    end
`ifdef APB_TIMEOUT_EN
                    else if (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        psel        <= '0;
                        penable     <= 1'b0;
                        rsp_valid   <= 1'b1;
                        rsp_err     <= 1'b1;
                        rsp_timeout <= 1'b1;
                        state       <= ST_RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
`endif
                end
                ST_RESP: begin
                    state     <= ST_IDLE;
                    cmd_ready <= 1'b1;
                end
                default: begin
                    state     <= ST_IDLE;
                    cmd_ready <= 1'b0;
                end
            endcase
        end
    end

`ifndef APB_TIMEOUT_EN
    assign rsp_timeout = 1'b0;
`endif

endmodule
